micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microprogram sequencer for the multi-cycle RV32 core. It holds the micro-PC (uPC) and reads an internal 16-entry microcode ROM.
- It drives the datapath control strobes and selects the next uPC: sequential, fetch, memory wait, or dispatch.
- It consumes the 4-bit dispatch address produced by the opcode decoder: 3 = R-type ALU, 6 = I-type ALU, 0 = unsupported.
- It also counts retired instructions and flags unsupported opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  step enable; low freezes the sequencer
- uPCd  in  4  dispatch address from the opcode decoder, sampled in DECODE
- mem_ready  in  1  instruction memory read data valid
- uPC  out  4  current micro-PC
- mem_rd  out  1  instruction memory read request
- ir_ld  out  1  load instruction register
- pc_inc  out  1  PC <= PC + 4
- rf_rd  out  1  register-file read / operand latch
- alu_src_imm  out  1  ALU operand B = immediate (0 = rs2)
- rf_we  out  1  register-file write enable
- illegal  out  1  one-cycle pulse: unsupported opcode dispatched
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset is asynchronous and active-low on rst_n; one clock domain (clk).
- While rst_n = 0:
  - uPC = 0, active = 0, illegal = 0, instret = 0.
  - All strobe outputs are 0.
- active flop:
  - Set on the first rising edge with rst_n = 1.
  - Strobes are ROM[uPC] fields AND active, so all strobes stay 0 during the first post-reset cycle.
- Microword fields: mem_rd, ir_ld, pc_inc, rf_rd, alu_src_imm, rf_we, seq_sel (2 bits).
- seq_sel encodings:
  - SEQ: uPC + 1
  - FETCH: 0
  - DISP: uPCd
  - WAIT: stay at uPC until mem_ready = 1, then uPC + 1
- Microprogram (address: asserted fields, seq_sel):
  - 0 FETCH: mem_rd, WAIT
  - 1 LOAD: ir_ld, pc_inc, SEQ
  - 2 DECODE: rf_rd, DISP
  - 3 R_EXEC: SEQ
  - 4 R_WB: rf_we, FETCH
  - 5: none, FETCH
  - 6 I_EXEC: alu_src_imm, SEQ
  - 7 I_WB: alu_src_imm, rf_we, FETCH
  - 8 to 15: none, FETCH (unreachable unless uPCd is corrupt)
- uPC update happens only on edges where en = 1 and active = 1. Otherwise uPC holds.
- Strobes ir_ld, pc_inc and rf_we are additionally ANDed with en, so a frozen step never repeats a side effect. mem_rd, rf_rd and alu_src_imm are not gated by en.
- Latency per instruction:
  - FETCH + 4 cycles when mem_ready is already high (0 → 1 → 2 → 3/6 → 4/7 → 0).
  - Each cycle of mem_ready low in FETCH adds one cycle.
- Unsupported opcode:
  - DECODE with uPCd = 0 causes the next uPC to be 0.
  - illegal is registered high for exactly the one cycle following that edge.
  - No register-file write occurs and instret does not change.
- Retire: on an enabled edge leaving address 4 or 7, instret increments by 1, modulo 2^CNT_W. It wraps from all-ones to 0 silently.
- mem_ready high outside FETCH is ignored.
- uPCd outside DECODE is ignored.
- Reset mid-instruction: everything returns immediately to reset values; a partially executed instruction is not counted.

Decomposition:
- Package micro_pkg holds:
  - seq_sel_t enum (SEQ, FETCH, DISP, WAIT).
  - Packed microword_t struct.
  - Address constants UA_FETCH = 0, UA_DECODE = 2, UA_R = 3, UA_I = 6.
  - The 16-entry ROM contents as a constant array.
- Sub-module micro_rom: combinational address → microword_t. It is shared with the verification bench for the golden model.

Test Plan:
- Reset, release, mem_ready = 1, uPCd = 3 held → uPC sequence 0,1,2,3,4,0 starting the cycle after release. rf_we = 1 only at uPC 4, alu_src_imm = 0 throughout, instret = 1.
- I-type: uPCd = 6, mem_ready = 1 → uPC 0,1,2,6,7,0. alu_src_imm = 1 at 6 and 7, rf_we at 7, instret increments.
- mem_ready low for 3 cycles in FETCH → uPC stays 0 with mem_rd = 1 for 4 cycles total, ir_ld exactly once.
- uPCd = 0 at DECODE → next uPC = 0, illegal = 1 for one cycle, rf_we never asserted, instret unchanged.
- en dropped for 2 cycles at uPC 1 → uPC holds at 1, ir_ld/pc_inc = 0 while en = 0, each pulses once after en returns.
- Preload instret to all-ones via CNT_W = 4 and 15 retirements, then one more → instret wraps to 0. rst_n asserted at uPC 6 → all outputs 0 asynchronously, count 0.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared types, entry points and microcode contents for the RV32 micro-sequencer.
package micro_pkg;

    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        FETCH = 2'd1,
        DISP  = 2'd2,
        WAIT  = 2'd3
    } seq_sel_t;

    typedef struct packed {
        logic     mem_rd;
        logic     ir_ld;
        logic     pc_inc;
        logic     rf_rd;
        logic     alu_src_imm;
        logic     rf_we;
        seq_sel_t seq_sel;
    } microword_t;

    localparam logic [3:0] UA_FETCH  = 4'd0;
    localparam logic [3:0] UA_DECODE = 4'd2;
    localparam logic [3:0] UA_R      = 4'd3;
    localparam logic [3:0] UA_I      = 4'd6;

    localparam microword_t MW_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FETCH};

    // Field order: mem_rd, ir_ld, pc_inc, rf_rd, alu_src_imm, rf_we, seq_sel
    localparam microword_t MICRO_ROM [16] = '{
        '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WAIT},   // 0 FETCH
        '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SEQ},    // 1 LOAD
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DISP},   // 2 DECODE
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEQ},    // 3 R_EXEC
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FETCH},  // 4 R_WB
        MW_NOP,
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SEQ},    // 6 I_EXEC
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FETCH},  // 7 I_WB
        MW_NOP, MW_NOP, MW_NOP, MW_NOP,
        MW_NOP, MW_NOP, MW_NOP, MW_NOP
    };

endpackage

// File: rtl/micro_rom.sv
// Combinational microcode ROM lookup: uPC -> microword.
module micro_rom
    import micro_pkg::*;
(
    input  logic [3:0] addr,
    output microword_t word
);

    assign word = MICRO_ROM[addr];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds uPC, decodes the ROM word into datapath strobes,
// counts retired instructions and flags unsupported dispatches.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       uPCd,
    input  logic             mem_ready,
    output logic [3:0]       uPC,
    output logic             mem_rd,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             rf_rd,
    output logic             alu_src_imm,
    output logic             rf_we,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    microword_t word;
    logic       active;
    logic       step;
    logic [3:0] next_upc;

    micro_rom u_rom (
        .addr (uPC),
        .word (word)
    );

    assign step = en & active;

    always_comb begin
        next_upc = uPC;
        case (word.seq_sel)
            SEQ:     next_upc = uPC + 4'd1;
            FETCH:   next_upc = UA_FETCH;
            DISP:    next_upc = uPCd;
            WAIT:    next_upc = mem_ready ? uPC + 4'd1 : uPC;
            default: next_upc = UA_FETCH;
        endcase
    end

    // Side-effecting strobes also need en so a frozen cycle cannot repeat them.
    assign mem_rd      = word.mem_rd      & active;
    assign rf_rd       = word.rf_rd       & active;
    assign alu_src_imm = word.alu_src_imm & active;
    assign ir_ld       = word.ir_ld       & step;
    assign pc_inc      = word.pc_inc      & step;
    assign rf_we       = word.rf_we       & step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uPC     <= UA_FETCH;
            active  <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            active  <= 1'b1;
            illegal <= 1'b0;
            if (step) begin
                uPC <= next_upc;
                if (uPC == UA_DECODE && uPCd == UA_FETCH)
                    illegal <= 1'b1;
                // The writeback word is the last of every legal instruction.
                if (word.rf_we)
                    instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer (CNT_W = 4 so the retire counter wraps quickly).
module tb_micro_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    uPCd;
    logic          mem_ready;
    logic [3:0]    uPC;
    logic          mem_rd, ir_ld, pc_inc, rf_rd, alu_src_imm, rf_we, illegal;
    logic [CW-1:0] instret;

    int n_chk  = 0;
    int n_fail = 0;

    micro_sequencer #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .uPCd        (uPCd),
        .mem_ready   (mem_ready),
        .uPC         (uPC),
        .mem_rd      (mem_rd),
        .ir_ld       (ir_ld),
        .pc_inc      (pc_inc),
        .rf_rd       (rf_rd),
        .alu_src_imm (alu_src_imm),
        .rf_we       (rf_we),
        .illegal     (illegal),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe vector order: mem_rd, ir_ld, pc_inc, rf_rd, alu_src_imm, rf_we
    task automatic st(input string tag, input logic [3:0] eu, input logic [5:0] es);
        chk({tag, "_upc"}, 32'(uPC), 32'(eu));
        chk({tag, "_strb"}, 32'({mem_rd, ir_ld, pc_inc, rf_rd, alu_src_imm, rf_we}), 32'(es));
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic run_r(input string tag);
        st({tag, "_0"}, 4'd0, 6'b100000); tick;
        st({tag, "_1"}, 4'd1, 6'b011000); tick;
        st({tag, "_2"}, 4'd2, 6'b000100); tick;
        st({tag, "_3"}, 4'd3, 6'b000000); tick;
        st({tag, "_4"}, 4'd4, 6'b000001); tick;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; uPCd = 4'd3; mem_ready = 1'b1;
        repeat (2) tick;
        st("rst", 4'd0, 6'b000000);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);

        rst_n = 1'b1;
        #1;
        st("first_cycle", 4'd0, 6'b000000);
        tick;

        // R-type
        run_r("rtype");
        st("rtype_end", 4'd0, 6'b100000);
        chk("rtype_instret", 32'(instret), 32'd1);

        // I-type
        uPCd = 4'd6;
        tick; st("itype_1", 4'd1, 6'b011000);
        tick; st("itype_2", 4'd2, 6'b000100);
        tick; st("itype_6", 4'd6, 6'b000010);
        tick; st("itype_7", 4'd7, 6'b000011);
        tick; st("itype_end", 4'd0, 6'b100000);
        chk("itype_instret", 32'(instret), 32'd2);

        // Memory wait: three low cycles keep FETCH for four cycles total
        uPCd = 4'd3;
        mem_ready = 1'b0;
        tick; st("wait_a", 4'd0, 6'b100000);
        tick; st("wait_b", 4'd0, 6'b100000);
        tick; st("wait_c", 4'd0, 6'b100000);
        mem_ready = 1'b1;
        tick; st("wait_load", 4'd1, 6'b011000);
        mem_ready = 1'b0;  // ignored outside FETCH
        tick; st("wait_dec", 4'd2, 6'b000100);
        mem_ready = 1'b1;
        tick; st("wait_r3", 4'd3, 6'b000000);
        tick; st("wait_r4", 4'd4, 6'b000001);
        tick; chk("wait_instret", 32'(instret), 32'd3);

        // Unsupported opcode
        tick; tick;
        st("ill_dec", 4'd2, 6'b000100);
        uPCd = 4'd0;
        tick;
        st("ill_next", 4'd0, 6'b100000);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_instret", 32'(instret), 32'd3);
        uPCd = 4'd3;
        tick;
        chk("ill_clear", 32'(illegal), 32'd0);
        st("ill_load", 4'd1, 6'b011000);

        // Freeze at LOAD for two edges
        en = 1'b0;
        #1; st("frz_a", 4'd1, 6'b000000);
        tick; st("frz_b", 4'd1, 6'b000000);
        tick; st("frz_c", 4'd1, 6'b000000);
        en = 1'b1;
        #1; st("frz_resume", 4'd1, 6'b011000);
        tick; st("frz_dec", 4'd2, 6'b000100);
        tick; tick; tick;
        chk("frz_instret", 32'(instret), 32'd4);

        // 11 more retirements reach all-ones, the 12th wraps to zero
        for (int i = 0; i < 12; i++) begin
            run_r("loop");
            chk("loop_instret", 32'(instret), 32'((5 + i) % 16));
        end
        chk("wrap_zero", 32'(instret), 32'd0);

        // One more retirement, then reset in the middle of an I-type
        run_r("pre_rst");
        chk("pre_rst_instret", 32'(instret), 32'd1);
        uPCd = 4'd6;
        tick; tick; tick;
        st("mid_i", 4'd6, 6'b000010);
        rst_n = 1'b0;
        #1;
        st("async_rst", 4'd0, 6'b000000);
        chk("async_rst_instret", 32'(instret), 32'd0);
        chk("async_rst_illegal", 32'(illegal), 32'd0);
        tick;
        st("held_rst", 4'd0, 6'b000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
